// File: rtl/gate_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// gate_truth_table_sweeper
//
// Walks every input combination of a combinational gate under test, holds
// each vector for a settle window, samples the gate's Result bit and builds a
// truth-table word. The captured table is compared against an expected table
// that is latched when the sweep is accepted.
//
// Parameters
//   NrOfInputs    number of gate inputs driven (1..4)
//   SettleCycles  cycles each vector is held before sampling (1..15)
//
// Ports
//   Clock          system clock, rising edge
//   Reset_n        asynchronous active-low reset
//   Start          sweep request, accepted only when idle
//   ExpectedTable  bit k = expected Result for GateInputs == k
//   GateResult     Result output of the gate under test
//   GateInputs     vector driven to the gate (bit0 -> Input_1, ...)
//   Busy           high while a sweep is running
//   Done           one-cycle pulse when a sweep completes
//   Pass           CapturedTable matched the latched table (valid from Done)
//   CapturedTable  sampled Result per vector
//
// Optional feature (macro SWEEPER_FAIL_INDEX_EN):
//   FirstFailIndex first vector whose sample disagreed with the expected bit
//   FailSeen       at least one vector disagreed during the sweep
// -----------------------------------------------------------------------------
module gate_truth_table_sweeper #(
    parameter int NrOfInputs   = 3,
    parameter int SettleCycles = 2
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic                         Start,
    input  logic [(2**NrOfInputs)-1:0]   ExpectedTable,
    input  logic                         GateResult,
    output logic [NrOfInputs-1:0]        GateInputs,
    output logic                         Busy,
    output logic                         Done,
    output logic                         Pass,
    output logic [(2**NrOfInputs)-1:0]   CapturedTable
`ifdef SWEEPER_FAIL_INDEX_EN
    ,
    output logic [NrOfInputs-1:0]        FirstFailIndex,
    output logic                         FailSeen
`endif
);

    localparam int                    TableW      = 2**NrOfInputs;
    localparam logic [NrOfInputs-1:0] LastIndex   = '1;
    localparam logic [3:0]            CountReload = 4'(SettleCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    state_t                  state_q,    state_d;
    logic [NrOfInputs-1:0]   index_q,    index_d;
    logic [3:0]              count_q,    count_d;
    logic [TableW-1:0]       expected_q, expected_d;
    logic [TableW-1:0]       captured_q, captured_d;
    logic                    busy_q,     busy_d;
    logic                    done_q,     done_d;
    logic                    pass_q,     pass_d;
`ifdef SWEEPER_FAIL_INDEX_EN
    logic                    fail_seen_q,  fail_seen_d;
    logic [NrOfInputs-1:0]   first_fail_q, first_fail_d;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        index_d    = index_q;
        count_d    = count_q;
        expected_d = expected_q;
        captured_d = captured_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
`ifdef SWEEPER_FAIL_INDEX_EN
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
`endif

        case (state_q)
            IDLE: begin
                index_d = '0;
                if (Start) begin
                    expected_d = ExpectedTable;
                    captured_d = '0;
                    pass_d     = 1'b0;
                    count_d    = CountReload;
                    busy_d     = 1'b1;
                    state_d    = SETTLE;
`ifdef SWEEPER_FAIL_INDEX_EN
                    fail_seen_d  = 1'b0;
                    first_fail_d = '0;
`endif
                end
            end

            SETTLE: begin
                if (count_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end

            SAMPLE: begin
                captured_d[index_q] = GateResult;
`ifdef SWEEPER_FAIL_INDEX_EN
                if (!fail_seen_q && (GateResult != expected_q[index_q])) begin
                    fail_seen_d  = 1'b1;
                    first_fail_d = index_q;
                end
`endif
                // Termination compares against all-ones so the index never wraps.
                if (index_q == LastIndex) begin
                    // Compare uses captured_d so the final sample is included
                    // and Pass is already valid in the Done cycle.
                    pass_d  = (captured_d == expected_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    index_d = '0;
                    state_d = FINISH;
                end else begin
                    index_d = index_q + 1'b1;
                    count_d = CountReload;
                    state_d = SETTLE;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its _d signal regardless of ordering.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            index_q    <= '0;
            count_q    <= '0;
            expected_q <= '0;
            captured_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef SWEEPER_FAIL_INDEX_EN
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            count_q    <= count_d;
            expected_q <= expected_d;
            captured_q <= captured_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
`ifdef SWEEPER_FAIL_INDEX_EN
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
`endif
        end
    end

    // The vector index doubles as the drive register; it is zero outside a sweep.
    assign GateInputs    = index_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Pass          = pass_q;
    assign CapturedTable = captured_q;
`ifdef SWEEPER_FAIL_INDEX_EN
    assign FailSeen       = fail_seen_q;
    assign FirstFailIndex = first_fail_q;
`endif

endmodule

// File: tb/tb_gate_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_gate_truth_table_sweeper
//
// Two sweeper instances: the default 3-input/2-settle build driving a modelled
// gate with one cycle of output latency, and a 1-input/1-settle build driving
// an inverter. Expected results are pushed to scoreboards when a sweep is
// issued; monitors pop and compare on every Done.
// -----------------------------------------------------------------------------
module tb_gate_truth_table_sweeper;

    localparam int N     = 3;
    localparam int S     = 2;
    localparam int SWEEP = 1 + (2**N) * (S + 1);

    typedef struct {
        logic [7:0] cap;
        logic       pass;
        logic       fseen;
        logic [2:0] ffi;
        int         done_cyc;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       Start, Start1;
    logic [7:0] ExpectedTable;
    logic [1:0] ExpectedTable1;
    logic       GateResult, GateResult1;
    logic [2:0] GateInputs;
    logic [0:0] GateInputs1;
    logic       Busy, Done, Pass, Busy1, Done1, Pass1;
    logic [7:0] CapturedTable;
    logic [1:0] CapturedTable1;
`ifdef SWEEPER_FAIL_INDEX_EN
    logic [2:0] FirstFailIndex;
    logic [0:0] FirstFailIndex1;
    logic       FailSeen, FailSeen1;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb_q[$];
    exp_t sb1_q[$];

    int         gate_kind;   // 0 NOR, 1 AND, 2 OR (inputs XORed with bubble mask)
    logic [2:0] gate_mask;
    logic [2:0] gi_d1;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    gate_truth_table_sweeper #(.NrOfInputs(3), .SettleCycles(2)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .ExpectedTable(ExpectedTable),
        .GateResult(GateResult), .GateInputs(GateInputs), .Busy(Busy), .Done(Done),
        .Pass(Pass), .CapturedTable(CapturedTable)
`ifdef SWEEPER_FAIL_INDEX_EN
        , .FirstFailIndex(FirstFailIndex), .FailSeen(FailSeen)
`endif
    );

    gate_truth_table_sweeper #(.NrOfInputs(1), .SettleCycles(1)) dut1 (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start1), .ExpectedTable(ExpectedTable1),
        .GateResult(GateResult1), .GateInputs(GateInputs1), .Busy(Busy1), .Done(Done1),
        .Pass(Pass1), .CapturedTable(CapturedTable1)
`ifdef SWEEPER_FAIL_INDEX_EN
        , .FirstFailIndex(FirstFailIndex1), .FailSeen(FailSeen1)
`endif
    );

    // Gate model: bubbled NOR/AND/OR over the inputs.
    function automatic logic gate_fn(int kind, logic [2:0] mask, logic [2:0] v);
        logic [2:0] x;
        x = v ^ mask;
        case (kind)
            0:       return ~|x;
            1:       return &x;
            default: return |x;
        endcase
    endfunction

    // Main gate answers one cycle after its inputs change, so an early sample
    // would read the previous vector's result.
    always @(posedge Clock) gi_d1 <= GateInputs;
    assign GateResult  = gate_fn(gate_kind, gate_mask, gi_d1);
    assign GateResult1 = ~GateInputs1[0];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the captured table is simply the gate's truth table.
    function automatic logic [7:0] truth_table(int kind, logic [2:0] mask);
        logic [7:0] t;
        for (int k = 0; k < 8; k++) t[k] = gate_fn(kind, mask, 3'(k));
        return t;
    endfunction

    function automatic exp_t make_exp(logic [7:0] truth, logic [7:0] tab, int start_cyc);
        exp_t e;
        e.cap      = truth;
        e.pass     = (truth == tab);
        e.fseen    = 1'b0;
        e.ffi      = 3'd0;
        e.done_cyc = start_cyc + SWEEP;
        for (int k = 7; k >= 0; k--) begin
            if (truth[k] != tab[k]) begin
                e.fseen = 1'b1;
                e.ffi   = 3'(k);
            end
        end
        return e;
    endfunction

    // ---------------- monitor: main instance ----------------
    logic       busy_prev = 1'b0;
    int         hold      = 0;
    logic [7:0] last_cap  = 8'h00;
    logic       last_pass = 1'b0;

    always @(negedge Clock) begin
        if (!Reset_n) begin
            last_cap  = 8'h00;
            last_pass = 1'b0;
        end else begin
            if (Busy) begin
                if (!busy_prev) hold = 0;
                check("gate_inputs_walk", 32'(GateInputs), 32'(hold / (S + 1)));
                check("pass_cleared_busy", 32'(Pass), 32'd0);
                hold++;
            end else if (!Done) begin
                check("gate_inputs_idle", 32'(GateInputs), 32'd0);
                check("captured_hold", 32'(CapturedTable), 32'(last_cap));
                check("pass_hold", 32'(Pass), 32'(last_pass));
            end
            if (Done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got Done=1 expected no sweep pending (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("captured", 32'(CapturedTable), 32'(e.cap));
                    check("pass", 32'(Pass), 32'(e.pass));
`ifdef SWEEPER_FAIL_INDEX_EN
                    check("fail_seen", 32'(FailSeen), 32'(e.fseen));
                    if (e.fseen) check("first_fail_index", 32'(FirstFailIndex), 32'(e.ffi));
`endif
                    last_cap  = e.cap;
                    last_pass = e.pass;
                end
            end
        end
        busy_prev = Busy;
    end

    // ---------------- monitor: 1-input instance ----------------
    always @(negedge Clock) begin
        if (Reset_n && Done1) begin
            if (sb1_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done1: got Done=1 expected no sweep pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb1_q.pop_front();
                check("done_cycle1", 32'(cyc), 32'(e.done_cyc));
                check("captured1", 32'(CapturedTable1), 32'(e.cap));
                check("pass1", 32'(Pass1), 32'(e.pass));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_start(logic [7:0] tab);
        @(posedge Clock);
        #1;
        ExpectedTable = tab;
        Start         = 1'b1;
        sb_q.push_back(make_exp(truth_table(gate_kind, gate_mask), tab, cyc));
        @(posedge Clock);
        #1;
        Start = 1'b0;
        check("busy_rise", 32'(Busy), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (sb_q.size() != 0 || sb1_q.size() != 0); i++)
            @(posedge Clock);
        if (sb_q.size() != 0 || sb1_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d sweeps pending expected 0",
                     sb_q.size() + sb1_q.size());
            sb_q.delete();
            sb1_q.delete();
        end
    endtask

    initial begin
        int k;
        Reset_n        = 1'b0;
        Start          = 1'b0;
        Start1         = 1'b0;
        ExpectedTable  = 8'h00;
        ExpectedTable1 = 2'b00;
        gate_kind      = 0;
        gate_mask      = 3'b000;

        repeat (3) @(posedge Clock);
        #1;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_pass", 32'(Pass), 32'd0);
        check("rst_captured", 32'(CapturedTable), 32'd0);
        check("rst_gate_inputs", 32'(GateInputs), 32'd0);
        Reset_n = 1'b1;

        // Plain NOR against the correct table.
        issue_start(8'h01);
        drain();

        // Bubbled NOR: correct table, then a wrong one (first fail at vector 0).
        gate_mask = 3'b001;
        issue_start(8'h02);
        drain();
        issue_start(8'h01);
        drain();

        // ExpectedTable changed mid-sweep has no effect.
        gate_mask = 3'b000;
        issue_start(8'h01);
        repeat (4) @(posedge Clock);
        #1;
        ExpectedTable = 8'hFF;
        drain();

        // Start held high: exactly two sweeps with Done 26 cycles apart.
        @(posedge Clock);
        #1;
        ExpectedTable = 8'h01;
        Start         = 1'b1;
        k             = cyc;
        sb_q.push_back(make_exp(truth_table(0, 3'b000), 8'h01, k));
        sb_q.push_back(make_exp(truth_table(0, 3'b000), 8'h01, k + SWEEP + 1));
        repeat (27) @(posedge Clock);
        #1;
        Start = 1'b0;
        drain();

        // Randomized gates and tables.
        for (int n = 0; n < 20; n++) begin
            logic [7:0] tab;
            gate_kind = int'($urandom_range(0, 2));
            gate_mask = 3'($urandom);
            tab = $urandom_range(0, 1) ? truth_table(gate_kind, gate_mask) : 8'($urandom);
            issue_start(tab);
            drain();
            repeat ($urandom_range(0, 3)) @(posedge Clock);
        end

        // 1-input inverter, SettleCycles=1: Done 5 cycles after Start.
        @(posedge Clock);
        #1;
        ExpectedTable1 = 2'b01;
        Start1         = 1'b1;
        begin
            exp_t e;
            e.cap = 8'h01; e.pass = 1'b1; e.fseen = 1'b0; e.ffi = 3'd0;
            e.done_cyc = cyc + 5;
            sb1_q.push_back(e);
        end
        @(posedge Clock);
        #1;
        Start1 = 1'b0;
        drain();

        // Reset asserted mid-sweep (cycle 10): immediate abort, no Done later.
        gate_kind = 0;
        gate_mask = 3'b000;
        issue_start(8'h01);
        repeat (9) @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_gate_inputs", 32'(GateInputs), 32'd0);
        check("abort_captured", 32'(CapturedTable), 32'd0);
        check("abort_pass", 32'(Pass), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        sb_q.delete();
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        repeat (40) @(posedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
